// File: rtl/ifu_fetch_frontend.sv
// -----------------------------------------------------------------------------
// ifu_fetch_frontend
//
// Instruction-fetch front end of the RV32I core.
//
// The block does three things:
//   * Brings the asynchronous boot controls (start_pulse, start_pc,
//     core_configuration) into the clk domain through two flop stages.
//   * Chooses the next fetch PC by priority: boot request, then branch
//     redirect, then sequential (+8). The choice is held in the PC register.
//   * Reads two consecutive instruction words per cycle from an internal
//     256x32 memory. The memory has two read ports and one write port.
//
// Ports
//   clk                      in   single clock, rising-edge active
//   rst_n                    in   synchronous reset, ACTIVE-HIGH (despite the name)
//   start_pulse              in   asynchronous core-start request
//   start_pc                 in   asynchronous boot PC
//   core_configuration       in   asynchronous configuration bits
//   bru_flush                in   branch-unit redirect request (clk domain)
//   bru_redir_pc             in   redirect target
//   core_running             in   instruction read enable
//   imem_wen                 in   instruction memory write enable
//   imem_wr_addr             in   instruction memory write word address
//   imem_wr_data             in   instruction memory write data
//   sync_start_pulse         out  start_pulse after two flop stages
//   sync_start_pc            out  start_pc after two flop stages
//   sync_core_configuration  out  core_configuration after two flop stages
//   pc_next                  out  arbitrated next PC (combinational)
//   pc                       out  registered current fetch PC
//   is_pc_unalign            out  pc_next is not word aligned (combinational)
//   inst_1                   out  mem[pc[9:2]], one cycle after pc
//   inst_2                   out  mem[pc[9:2] + 1], wraps at the top of memory
// -----------------------------------------------------------------------------
module ifu_fetch_frontend #(
    parameter int unsigned PC_WIDTH           = 32,
    parameter int unsigned INST_WIDTH         = 32,
    parameter int unsigned INST_MEM_DEPTH     = 256,
    parameter int unsigned INST_MEM_DEPTH_BIT = 8,
    parameter int unsigned EXCEPTION_NUM      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,

    // Asynchronous boot controls
    input  logic                          start_pulse,
    input  logic [PC_WIDTH-1:0]           start_pc,
    input  logic [EXCEPTION_NUM-1:0]      core_configuration,

    // Branch redirect
    input  logic                          bru_flush,
    input  logic [PC_WIDTH-1:0]           bru_redir_pc,

    // Memory control
    input  logic                          core_running,
    input  logic                          imem_wen,
    input  logic [INST_MEM_DEPTH_BIT-1:0] imem_wr_addr,
    input  logic [INST_WIDTH-1:0]         imem_wr_data,

    // Synchronised boot controls
    output logic                          sync_start_pulse,
    output logic [PC_WIDTH-1:0]           sync_start_pc,
    output logic [EXCEPTION_NUM-1:0]      sync_core_configuration,

    // Fetch PC
    output logic [PC_WIDTH-1:0]           pc_next,
    output logic [PC_WIDTH-1:0]           pc,
    output logic                          is_pc_unalign,

    // Fetched instruction pair
    output logic [INST_WIDTH-1:0]         inst_1,
    output logic [INST_WIDTH-1:0]         inst_2
);

    // Each fetch covers two 4-byte instructions.
    localparam logic [PC_WIDTH-1:0] FetchStride = PC_WIDTH'(8);

    // The increment that gives the second read address. The add is done at
    // memory-address width, so the top word wraps back to word 0.
    localparam logic [INST_MEM_DEPTH_BIT-1:0] AddrOne = INST_MEM_DEPTH_BIT'(1);

    // -------------------------------------------------------------------------
    // Two-stage synchroniser
    // -------------------------------------------------------------------------
    // The first stage can go metastable. Only the second stage is seen by
    // the rest of the design. The synchroniser does not detect edges: a
    // level held for N cycles comes out held for N cycles.
    logic                     start_pulse_meta_q;
    logic [PC_WIDTH-1:0]      start_pc_meta_q;
    logic [EXCEPTION_NUM-1:0] core_cfg_meta_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            start_pulse_meta_q      <= 1'b0;
            start_pc_meta_q         <= '0;
            core_cfg_meta_q         <= '0;
            sync_start_pulse        <= 1'b0;
            sync_start_pc           <= '0;
            sync_core_configuration <= '0;
        end else begin
            start_pulse_meta_q      <= start_pulse;
            start_pc_meta_q         <= start_pc;
            core_cfg_meta_q         <= core_configuration;
            sync_start_pulse        <= start_pulse_meta_q;
            sync_start_pc           <= start_pc_meta_q;
            sync_core_configuration <= core_cfg_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next-PC arbitration
    // -------------------------------------------------------------------------
    // A boot request beats a branch redirect. The sequential increment is
    // modulo 2^PC_WIDTH and wraps without any indication.
    always_comb begin
        pc_next = pc + FetchStride;
        if (sync_start_pulse) begin
            pc_next = sync_start_pc;
        end else if (bru_flush) begin
            pc_next = bru_redir_pc;
        end
    end

    // This is a flag only. An unaligned target is still loaded, and the
    // memory address ignores the low two bits.
    assign is_pc_unalign = |pc_next[1:0];

    // -------------------------------------------------------------------------
    // PC register
    // -------------------------------------------------------------------------
    // The PC advances every cycle, whether or not the core is running.
    // Gating the fetch is done only on the memory read side.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Instruction memory: 256 x 32, two read ports, one write port
    // -------------------------------------------------------------------------
    logic [INST_WIDTH-1:0]         mem [INST_MEM_DEPTH];
    logic [INST_MEM_DEPTH_BIT-1:0] rd_addr_1;
    logic [INST_MEM_DEPTH_BIT-1:0] rd_addr_2;

    // Word address. PC bits above the memory range are ignored.
    assign rd_addr_1 = pc[INST_MEM_DEPTH_BIT+1:2];
    assign rd_addr_2 = rd_addr_1 + AddrOne;

    // The write port is independent of core_running. The contents are
    // never reset.
    always_ff @(posedge clk) begin
        if (imem_wen) begin
            mem[imem_wr_addr] <= imem_wr_data;
        end
    end

    // Synchronous read with one cycle of latency. The read sees the array
    // value from before the edge, so a write to the same word on the same
    // edge returns the old data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            inst_1 <= '0;
            inst_2 <= '0;
        end else if (core_running) begin
            inst_1 <= mem[rd_addr_1];
            inst_2 <= mem[rd_addr_2];
        end
    end

endmodule

// File: tb/tb_ifu_fetch_frontend.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for ifu_fetch_frontend.
//
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, or 1 ns later for the combinational outputs. rst_n is
// active-high.
// -----------------------------------------------------------------------------
module tb_ifu_fetch_frontend;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_pulse;
    logic [31:0] start_pc;
    logic [1:0]  core_configuration;
    logic        bru_flush;
    logic [31:0] bru_redir_pc;
    logic        core_running;
    logic        imem_wen;
    logic [7:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;

    logic        sync_start_pulse;
    logic [31:0] sync_start_pc;
    logic [1:0]  sync_core_configuration;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        is_pc_unalign;
    logic [31:0] inst_1;
    logic [31:0] inst_2;

    int checks = 0;
    int errors = 0;

    ifu_fetch_frontend dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start_pulse             (start_pulse),
        .start_pc                (start_pc),
        .core_configuration      (core_configuration),
        .bru_flush               (bru_flush),
        .bru_redir_pc            (bru_redir_pc),
        .core_running            (core_running),
        .imem_wen                (imem_wen),
        .imem_wr_addr            (imem_wr_addr),
        .imem_wr_data            (imem_wr_data),
        .sync_start_pulse        (sync_start_pulse),
        .sync_start_pc           (sync_start_pc),
        .sync_core_configuration (sync_core_configuration),
        .pc_next                 (pc_next),
        .pc                      (pc),
        .is_pc_unalign           (is_pc_unalign),
        .inst_1                  (inst_1),
        .inst_2                  (inst_2)
    );

    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short, so a run that lasts far
    // longer than expected is reported as a failure instead of hanging.
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n              = 1'b1;
        start_pulse        = 1'b0;
        start_pc           = '0;
        core_configuration = '0;
        bru_flush          = 1'b0;
        bru_redir_pc       = '0;
        core_running       = 1'b0;
        imem_wen           = 1'b0;
        imem_wr_addr       = '0;
        imem_wr_data       = '0;

        // Reset
        step();
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_inst_1", inst_1, 32'h0);
        check("reset_inst_2", inst_2, 32'h0);
        check("reset_sync_pulse", {31'b0, sync_start_pulse}, 32'h0);
        check("reset_sync_pc", sync_start_pc, 32'h0);
        rst_n = 1'b0;
        #1;
        check("first_pc_next", pc_next, 32'h8);

        // Idle sequential fetch
        step();
        check("idle_pc_8", pc, 32'h8);
        step();
        check("idle_pc_10", pc, 32'h10);
        check("idle_inst_1", inst_1, 32'h0);

        // Preload mem[i] = i through the write port
        for (int i = 0; i < 256; i++) begin
            imem_wen     = 1'b1;
            imem_wr_addr = 8'(i);
            imem_wr_data = 32'(i);
            step();
        end
        imem_wen = 1'b0;
        check("preload_inst_frozen", inst_1, 32'h0);

        // Boot: start request for one cycle
        start_pulse        = 1'b1;
        start_pc           = 32'h10;
        core_configuration = 2'b01;
        step();
        start_pulse = 1'b0;
        check("boot_sync_after_1", {31'b0, sync_start_pulse}, 32'h0);
        step();
        check("boot_sync_pulse", {31'b0, sync_start_pulse}, 32'h1);
        check("boot_sync_pc", sync_start_pc, 32'h10);
        check("boot_sync_cfg", {30'b0, sync_core_configuration}, 32'h1);
        check("boot_pc_next", pc_next, 32'h10);
        step();
        check("boot_pc", pc, 32'h10);
        check("boot_pulse_one_cycle", {31'b0, sync_start_pulse}, 32'h0);
        check("boot_pc_next_seq", pc_next, 32'h18);

        // Fetch with the core running
        core_running = 1'b1;
        step();
        check("fetch_pc_18", pc, 32'h18);
        check("fetch_inst_1", inst_1, 32'd4);
        check("fetch_inst_2", inst_2, 32'd5);
        step();
        check("fetch_pc_20", pc, 32'h20);
        check("fetch2_inst_1", inst_1, 32'd6);

        // Read address wraps from word 255 back to word 0
        bru_flush    = 1'b1;
        bru_redir_pc = 32'h3FC;
        #1;
        check("wrap_pc_next", pc_next, 32'h3FC);
        check("wrap_aligned", {31'b0, is_pc_unalign}, 32'h0);
        step();
        bru_flush = 1'b0;
        check("wrap_pc", pc, 32'h3FC);
        step();
        check("wrap_inst_1", inst_1, 32'd255);
        check("wrap_inst_2", inst_2, 32'd0);
        check("wrap_pc_next_seq", pc, 32'h404);

        // Unaligned redirect
        bru_flush    = 1'b1;
        bru_redir_pc = 32'h41;
        #1;
        check("unalign_flag", {31'b0, is_pc_unalign}, 32'h1);
        check("redir_pc_next", pc_next, 32'h41);
        step();
        bru_flush = 1'b0;
        check("redir_pc", pc, 32'h41);
        check("high_pc_bits_ignored", inst_1, 32'd1);
        step();
        check("redir_inst_1", inst_1, 32'd16);
        check("redir_inst_2", inst_2, 32'd17);
        check("redir_pc_49", pc, 32'h49);
        step();
        check("redir_pc_51", pc, 32'h51);

        bru_flush    = 1'b1;
        bru_redir_pc = 32'hFF;
        step();
        bru_flush = 1'b0;
        check("redir_ff_pc", pc, 32'hFF);
        step();
        check("redir_ff_inst_1", inst_1, 32'd63);
        check("redir_ff_inst_2", inst_2, 32'd64);

        // Boot request and redirect in the same cycle: boot wins
        start_pulse = 1'b1;
        start_pc    = 32'h100;
        step();
        start_pulse = 1'b0;
        step();
        bru_flush    = 1'b1;
        bru_redir_pc = 32'h41;
        #1;
        check("collide_pc_next", pc_next, 32'h100);
        check("collide_aligned", {31'b0, is_pc_unalign}, 32'h0);
        step();
        bru_flush = 1'b0;
        check("collide_pc", pc, 32'h100);

        // Same-edge write and read of word 3 returns the old data
        bru_flush    = 1'b1;
        bru_redir_pc = 32'h0C;
        step();
        bru_flush    = 1'b0;
        imem_wen     = 1'b1;
        imem_wr_addr = 8'd3;
        imem_wr_data = 32'hDEADBEEF;
        check("rw_pc", pc, 32'h0C);
        step();
        imem_wen = 1'b0;
        check("rw_read_first", inst_1, 32'd3);
        check("rw_inst_2", inst_2, 32'd4);
        bru_flush    = 1'b1;
        bru_redir_pc = 32'h0C;
        step();
        bru_flush = 1'b0;
        step();
        check("rw_new_data", inst_1, 32'hDEADBEEF);
        check("rw_new_inst_2", inst_2, 32'd4);

        // core_running low holds the instruction outputs
        core_running = 1'b0;
        step();
        check("freeze_inst_1", inst_1, 32'hDEADBEEF);
        check("freeze_inst_2", inst_2, 32'd4);

        // Reset during operation clears all flops but leaves the memory alone
        rst_n        = 1'b1;
        core_running = 1'b1;
        step();
        check("midrst_pc", pc, 32'h0);
        check("midrst_inst_1", inst_1, 32'h0);
        check("midrst_sync_cfg", {30'b0, sync_core_configuration}, 32'h0);
        check("midrst_sync_pc", sync_start_pc, 32'h0);
        rst_n = 1'b0;
        step();
        check("postrst_pc", pc, 32'h8);
        step();
        check("postrst_sync_cfg", {30'b0, sync_core_configuration}, 32'h1);
        check("mem_kept_inst_1", inst_1, 32'd2);
        check("mem_kept_inst_2", inst_2, 32'hDEADBEEF);

        // The sequential PC wraps modulo 2^32
        bru_flush    = 1'b1;
        bru_redir_pc = 32'hFFFF_FFF8;
        step();
        bru_flush = 1'b0;
        check("pcwrap_pc", pc, 32'hFFFF_FFF8);
        #1;
        check("pcwrap_pc_next", pc_next, 32'h0);
        step();
        check("pcwrap_pc_zero", pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_frontend.md
Name: ifu_fetch_frontend

Overview:
- Instruction-fetch front end of the RV32I core.
- Synchronises the asynchronous start controls through two flip-flop stages.
- Selects the next PC from start / branch-redirect / sequential sources and holds it in a PC register.
- Reads two consecutive 32-bit instructions per cycle from an internal 256x32 instruction memory with two read ports and one write port.

Parameters:
- PC_WIDTH, 32, PC and address width.
- INST_WIDTH, 32, instruction and memory word width.
- INST_MEM_DEPTH, 256, memory words; INST_MEM_DEPTH_BIT = 8.
- EXCEPTION_NUM, 2, width of core_configuration.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-high: reset takes effect at a rising clk edge while rst_n=1.
- start_pulse  in  1  asynchronous core-start request.
- start_pc  in  PC_WIDTH  asynchronous boot PC.
- core_configuration  in  EXCEPTION_NUM  asynchronous configuration bits.
- bru_flush  in  1  branch-unit redirect request (synchronous to clk).
- bru_redir_pc  in  PC_WIDTH  redirect target.
- core_running  in  1  memory read enable (cen).
- imem_wen  in  1  memory write enable.
- imem_wr_addr  in  8  memory write word address.
- imem_wr_data  in  INST_WIDTH  memory write data.
- sync_start_pulse  out  1  synchronised start_pulse.
- sync_start_pc  out  PC_WIDTH  synchronised start_pc.
- sync_core_configuration  out  EXCEPTION_NUM  synchronised configuration.
- pc_next  out  PC_WIDTH  combinational next PC (arbitration result).
- pc  out  PC_WIDTH  registered current fetch PC.
- is_pc_unalign  out  1  pc_next[1:0] != 0 (combinational).
- inst_1  out  INST_WIDTH  mem[pc[9:2]].
- inst_2  out  INST_WIDTH  mem[pc[9:2]+1].

Behaviour:
- Synchroniser:
  - Each bit of start_pulse, start_pc and core_configuration passes through two flops.
  - Output = input sampled two rising edges earlier.
  - Reset clears both stages to 0.
  - No edge detection: a level held N cycles appears for N cycles.
- PC arbitration (combinational), in strict priority:
  1. sync_start_pulse=1 -> pc_next = sync_start_pc.
  2. Else bru_flush=1 -> pc_next = bru_redir_pc.
  3. Else pc_next = pc + 8 (two instructions per fetch); modulo 2^32, wraps silently.
- is_pc_unalign:
  - Flags pc_next[1:0] != 0 only.
  - An unaligned PC is still loaded and used; the memory address ignores bits [1:0].
- PC register:
  - pc <= pc_next every edge, unconditionally, independent of core_running.
  - Reset value 0; the cycle after reset, pc_next = 8.
- Memory:
  - 256 words, array named mem; contents are not reset.
  - Read address ra = pc[9:2]; pc bits above 9 are ignored.
  - Read is synchronous, one-cycle latency: on an edge with core_running=1, inst_1 <= mem[ra] and inst_2 <= mem[(ra+1) mod 256], so 255 wraps to 0.
  - core_running=0: inst_1 and inst_2 hold their previous values.
  - Reset clears inst_1 and inst_2 to 0.
  - Write is synchronous: mem[imem_wr_addr] <= imem_wr_data when imem_wen=1, independent of core_running.
  - Same-edge read and write of the same word: read returns old data (read-first).
- Latencies:
  - start_pulse to sync_start_pulse: 2 edges.
  - start_pulse to pc = start_pc: 3 edges.
  - pc to instructions: 1 edge.
- Mid-operation reset: at the next edge, all flops (both sync stages, pc, inst_1, inst_2) return to 0; memory is untouched.

Test Plan:
- Reset, then idle with all inputs 0 -> pc = 0, 8, 0x10, … each cycle; inst_1 = inst_2 = 0 while core_running = 0; sync outputs = 0.
- Boot: start_pulse=1, start_pc=0x10, core_configuration=2'b01 for one cycle -> sync_start_pulse high exactly one cycle, 2 edges later, with sync_start_pc=0x10 and sync_core_configuration=01; pc=0x10 next edge, then 0x18, 0x20.
- Fetch with mem[i]=i preloaded and core_running=1: pc=0x10 -> next cycle inst_1=4, inst_2=5. pc=0x3FC -> inst_1=255, inst_2=0 (wrap).
- Redirect: bru_flush=1, bru_redir_pc=0x41 -> is_pc_unalign=1 that cycle; pc=0x41, then inst_1=16, inst_2=17; pc continues 0x49, 0x51. bru_flush with 0xFF -> pc=0xFF, inst_1=63, inst_2=64.
- Collision: sync_start_pulse=1 (sync_start_pc=0x100) and bru_flush=1 (0x41) in the same cycle -> pc=0x100, is_pc_unalign=0.
- Memory write: imem_wen=1, imem_wr_addr=3, imem_wr_data=0xDEADBEEF while pc reads word 3 the same edge -> old value returned; next read of word 3 returns 0xDEADBEEF. core_running=0 -> inst outputs frozen.
